// File: rtl/mem_access_seq.sv
// Multicycle load/store sequencer: aligns a CPU access onto a word-wide memory
// port, waits for the acknowledge and returns the extended load result.
module mem_access_seq #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  acc_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err_align,
    output logic        err_timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_WAIT   = 3'd2,
        S_FINISH = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    // Last counter value tolerated without ack; only meaningful when TIMEOUT > 0.
    localparam logic [CNT_W-1:0] TO_LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t            state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        type_q, type_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       mdr_q, mdr_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              to_fault_q, to_fault_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              acc_byte;
    logic              acc_half;
    logic              misaligned;
    logic [3:0]        be_calc;
    logic [31:0]       wdata_calc;
    logic [7:0]        lane_byte;
    logic [15:0]       lane_half;
    logic [31:0]       load_result;

    // Access decode from the latched request; unused encodings behave as word.
    always_comb begin
        acc_byte   = (type_q == 3'b001) || (type_q == 3'b011);
        acc_half   = (type_q == 3'b010) || (type_q == 3'b100);
        misaligned = (acc_half && addr_q[0]) ||
                     (!acc_byte && !acc_half && (addr_q[1:0] != 2'b00));

        be_calc    = 4'b1111;
        wdata_calc = wdata_q;
        if (acc_byte) begin
            be_calc    = 4'b0001 << addr_q[1:0];
            wdata_calc = {4{wdata_q[7:0]}};
        end else if (acc_half) begin
            be_calc    = 4'b0011 << {addr_q[1], 1'b0};
            wdata_calc = {2{wdata_q[15:0]}};
        end
    end

    // Lane select and extension of the MDR for the returned load value.
    always_comb begin
        lane_byte = mdr_q[{addr_q[1:0], 3'b000} +: 8];
        lane_half = addr_q[1] ? mdr_q[31:16] : mdr_q[15:0];
        case (type_q)
            3'b001:  load_result = {{24{lane_byte[7]}}, lane_byte};
            3'b011:  load_result = {24'd0, lane_byte};
            3'b010:  load_result = {{16{lane_half[15]}}, lane_half};
            3'b100:  load_result = {16'd0, lane_half};
            default: load_result = mdr_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            is_store_q  <= 1'b0;
            type_q      <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            cnt_q       <= '0;
            mdr_q       <= 32'd0;
            rdata_q     <= 32'd0;
            to_fault_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            mdr_q       <= mdr_d;
            rdata_q     <= rdata_d;
            to_fault_q  <= to_fault_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        type_d      = type_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        mdr_d       = mdr_q;
        rdata_d     = rdata_q;
        to_fault_d  = to_fault_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    is_store_d = is_store;
                    type_d     = acc_type;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (misaligned) begin
                    to_fault_d = 1'b0;
                    state_d    = S_FAULT;
                end else begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = is_store_q;
                    mem_addr_d  = {addr_q[31:2], 2'b00};
                    mem_be_d    = be_calc;
                    mem_wdata_d = wdata_calc;
                    cnt_d       = '0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                // An ack in the limit cycle still completes the access.
                if (mem_ack) begin
                    mdr_d     = mem_rdata;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = S_FINISH;
                end else if ((TIMEOUT > 0) && (cnt_q == TO_LIMIT)) begin
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    to_fault_d = 1'b1;
                    state_d    = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FINISH: begin
                if (!is_store_q) begin
                    rdata_d = load_result;
                end
                state_d = S_IDLE;
            end
            S_FAULT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FINISH);
    assign err_align   = (state_q == S_FAULT) && !to_fault_q;
    assign err_timeout = (state_q == S_FAULT) && to_fault_q;
    // The load result is visible during the done cycle and held afterwards.
    assign rdata       = (state_q == S_FINISH && !is_store_q) ? load_result : rdata_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Randomized scoreboard bench for mem_access_seq with a small byte-level
// reference model and a memory responder with programmable ack delay.
module tb_mem_access_seq;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        is_store;
    logic [2:0]  acc_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err_align;
    logic        err_timeout;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    mem_access_seq #(.TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .acc_type(acc_type), .addr(addr), .wdata(wdata), .busy(busy),
        .done(done), .rdata(rdata), .err_align(err_align),
        .err_timeout(err_timeout), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 done, 1 align error, 2 timeout
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } mreq_t;

    resp_t       exp_resp[$];
    mreq_t       exp_mem[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_txn = 0;
    int          resp_delay = 0;
    logic [31:0] resp_data = 32'd0;
    logic [31:0] last_rdata = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: compute memory request and response from the access rules.
    task automatic issue(input logic st, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] mw, input int dly);
        logic [7:0]  b[4];
        logic [7:0]  v8;
        logic [15:0] v16;
        logic        is_b, is_h, sgn, bad;
        mreq_t       m;
        resp_t       r;
        int          n;
        is_b = (t == 3'd1) || (t == 3'd3);
        is_h = (t == 3'd2) || (t == 3'd4);
        sgn  = (t == 3'd1) || (t == 3'd2);
        bad  = (is_h && a[0]) || (!is_b && !is_h && a[1:0] != 2'b00);
        for (int i = 0; i < 4; i++) b[i] = mw[8*i +: 8];

        m.addr = {a[31:2], 2'b00};
        m.we   = st;
        if (is_b) begin
            m.be = 4'd1 << a[1:0];
            for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = wd[7:0];
        end else if (is_h) begin
            m.be = a[1] ? 4'b1100 : 4'b0011;
            for (int i = 0; i < 4; i++) m.wdata[8*i +: 8] = (i % 2 == 1) ? wd[15:8] : wd[7:0];
        end else begin
            m.be    = 4'b1111;
            m.wdata = wd;
        end

        if (bad) begin
            r.kind = 1; r.rdata = last_rdata; r.cyc = cyc + 2;
        end else if (dly >= TO) begin
            r.kind = 2; r.rdata = last_rdata; r.cyc = cyc + 2 + TO;
        end else begin
            r.kind = 0; r.cyc = cyc + 3 + dly;
            if (!st) begin
                if (is_b) begin
                    v8 = b[a[1:0]];
                    last_rdata = sgn ? {{24{v8[7]}}, v8} : {24'd0, v8};
                end else if (is_h) begin
                    v16 = {b[{a[1], 1'b1}], b[{a[1], 1'b0}]};
                    last_rdata = sgn ? {{16{v16[15]}}, v16} : {16'd0, v16};
                end else begin
                    last_rdata = mw;
                end
            end
            r.rdata = last_rdata;
        end
        if (!bad) exp_mem.push_back(m);
        exp_resp.push_back(r);

        resp_delay = dly;
        resp_data  = mw;
        start = 1'b1; is_store = st; acc_type = t; addr = a; wdata = wd;
        @(negedge clk);
        chk("busy_in_check", busy, 1'b1);
        // A start while busy must be ignored.
        start = 1'b1; is_store = $urandom; acc_type = 3'($urandom);
        addr = $urandom; wdata = $urandom;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("return_to_idle", busy, 1'b0);
    endtask

    // Memory responder: checks the request and acks after resp_delay cycles.
    initial begin : responder
        int    k;
        mreq_t cur;
        k = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        cur = '{default: '0};
        forever begin
            @(negedge clk);
            if (rst_n && mem_req) begin
                if (k == 0) begin
                    if (exp_mem.size() == 0) begin
                        chk("unexpected_mem_req", {31'd0, mem_req}, 32'd0);
                    end else begin
                        cur = exp_mem.pop_front();
                    end
                end
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_be", {28'd0, mem_be}, {28'd0, cur.be});
                chk("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
                if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                mem_ack   = (k == resp_delay);
                mem_rdata = mem_ack ? resp_data : $urandom;
                k++;
            end else begin
                k = 0;
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Response monitor: pops the scoreboard whenever done or an error pulses.
    initial begin : monitor
        resp_t r;
        int    kind;
        forever begin
            @(negedge clk);
            if (rst_n && (done || err_align || err_timeout)) begin
                kind = done ? 0 : (err_align ? 1 : 2);
                chk("single_pulse", 32'(int'(done) + int'(err_align) + int'(err_timeout)), 32'd1);
                if (exp_resp.size() == 0) begin
                    chk("unexpected_response", 32'(kind), 32'hFFFF_FFFF);
                end else begin
                    r = exp_resp.pop_front();
                    chk("resp_kind", 32'(kind), 32'(r.kind));
                    chk("resp_rdata", rdata, r.rdata);
                    chk("resp_cycle", 32'(cyc), 32'(r.cyc));
                    $display("txn %0d: kind=%0d rdata=%h cycle=%0d", n_txn, kind, rdata, cyc);
                end
                n_txn++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int dly;
        logic [31:0] a;
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; acc_type = 3'd0;
        addr = 32'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_err_align", err_align, 1'b0);
        chk("rst_err_timeout", err_timeout, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b0, 3'd1, 32'h0000_1003, 32'h0, 32'h8011_2233, 0);  // lb  -> FFFFFF80
        issue(1'b0, 3'd4, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0);  // lhu -> 0000BEEF
        issue(1'b0, 3'd2, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 1);  // lh  -> FFFFBEEF
        issue(1'b1, 3'd1, 32'h0000_0001, 32'hA5, 32'h1234_5678, 0); // sb, rdata kept
        issue(1'b0, 3'd0, 32'h0000_0006, 32'h0, 32'h1111_1111, 0);  // misaligned word
        issue(1'b0, 3'd0, 32'h0000_0040, 32'h0, 32'h2222_2222, 99); // timeout
        issue(1'b0, 3'd0, 32'h0000_0044, 32'h0, 32'h3333_3333, TO - 1); // ack at limit

        // Reset asserted while waiting on memory.
        exp_mem.push_back('{addr: 32'h0000_3000, be: 4'hF, we: 1'b0, wdata: 32'h0});
        resp_delay = 100;
        start = 1'b1; is_store = 1'b0; acc_type = 3'd0; addr = 32'h0000_3000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("wait_mem_req", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rdata", rdata, 32'd0);
        chk("midrst_mem_be", {28'd0, mem_be}, 32'd0);
        last_rdata = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 3'd3, 32'h0000_5002, 32'h0, 32'h00F7_0000, 2);  // lbu -> F7

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            dly = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(TO, TO + 2);
            issue(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, $urandom, dly);
        end

        repeat (5) @(negedge clk);
        chk("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
        chk("mem_queue_empty", 32'(exp_mem.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Multicycle load/store sequencer between the CPU control FSM and the data memory port.
- Takes one access request (address, type, store data), checks alignment, and drives a word-aligned memory request with byte enables and lane-shifted store data.
- Waits for the memory acknowledge, latches the read word into an internal MDR, and returns it sign- or zero-extended per load type.
- Flags misaligned accesses and memory timeouts without touching memory.

Parameters:
- TIMEOUT, 16, cycles waited in WAIT for mem_ack before err_timeout; 0 disables the timeout.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request strobe; sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load; sampled with start.
- acc_type  in  3  access type encoding: 000 word, 001 byte signed, 010 half signed, 011 byte unsigned, 100 half unsigned; 101-111 treated as word.
- addr  in  32  byte address; sampled with start.
- wdata  in  32  store data, right-justified; sampled with start.
- busy  out  1  high from the cycle after an accepted start until the cycle done or err is pulsed.
- done  out  1  one-cycle pulse when an access completes successfully.
- rdata  out  32  extended load result; valid from the done pulse until the next accepted start.
- err_align  out  1  one-cycle pulse for a misaligned access.
- err_timeout  out  1  one-cycle pulse when the memory does not acknowledge in time.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  write enable, valid while mem_req is high.
- mem_addr  out  32  {addr[31:2], 2'b00}.
- mem_be  out  4  byte enables, little-endian lanes.
- mem_wdata  out  32  store data replicated or shifted into the addressed lane.
- mem_rdata  in  32  read data, valid in the cycle mem_ack is high.
- mem_ack  in  1  memory completion; ignored outside WAIT.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0, including rdata and the internal MDR.
  - Wait counter clears.
- States: IDLE, CHECK, WAIT, FINISH, FAULT.
- IDLE:
  - start=1 latches is_store, acc_type, addr and wdata, then goes to CHECK.
  - start=0 stays in IDLE.
  - busy=0 in IDLE.
- CHECK (one cycle):
  - Misaligned when a half access has addr[0]=1, or a word access has addr[1:0]≠00.
  - Misaligned goes to FAULT. Otherwise mem_req is asserted on the next edge and the state goes to WAIT.
- Byte enables:
  - Byte access: 4'b0001 << addr[1:0].
  - Half access: 4'b0011 << {addr[1],1'b0}.
  - Word access: 4'b1111.
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- WAIT:
  - mem_req=1. mem_addr, mem_be, mem_we and mem_wdata are held stable.
  - The wait counter increments each cycle that mem_ack=0.
  - mem_ack=1: MDR <= mem_rdata, mem_req drops on the next edge, and the state goes to FINISH.
  - With TIMEOUT>0, the counter reaching TIMEOUT-1 while mem_ack=0 drops mem_req and goes to FAULT.
  - mem_ack on the same cycle as the timeout limit has priority: the access completes.
- FINISH (one cycle):
  - done=1. For loads, rdata is registered from the MDR lane selected by the latched addr[1:0].
  - Extension: byte signed {{24{b[7]}},b}; byte unsigned {24'd0,b}; half signed {{16{h[15]}},h}; half unsigned {16'd0,h}; word MDR.
  - For stores, rdata keeps its previous value.
  - Goes to IDLE.
- FAULT (one cycle):
  - err_align or err_timeout pulses, matching the cause.
  - No memory write has occurred: mem_req is never asserted for a misaligned access.
  - Goes to IDLE. rdata is unchanged.
- Back-to-back accesses: start held high is accepted again in the IDLE cycle after FINISH or FAULT. Minimum access time is start → done in 3 cycles with zero-wait memory.
- start outside IDLE is ignored and not queued.
- Reset asserted mid-access: mem_req drops immediately (async); no done or err pulse is produced.

Test Plan:
- Load byte signed: addr=0x1003, mem_rdata=0x80112233, ack in first WAIT cycle -> mem_be=1000, mem_addr=0x1000, done after 3 cycles, rdata=0xFFFFFF80.
- Load half unsigned: addr=0x2002, mem_rdata=0xBEEF1234 -> mem_be=1100, rdata=0x0000BEEF. The same access as half signed -> rdata=0xFFFFBEEF.
- Store byte: addr=0x0001, wdata=0x000000A5 -> mem_we=1, mem_be=0010, mem_wdata=0xA5A5A5A5, done pulse, rdata unchanged.
- Misaligned word: load at addr=0x0006 -> err_align pulse 2 cycles after start, mem_req never high, done never high.
- Timeout: TIMEOUT=4, mem_ack held 0 -> mem_req high for 4 cycles, then err_timeout pulse and return to IDLE. With ack arriving exactly in the 4th cycle -> done instead of err_timeout.
- Reset during WAIT: rst_n low mid-WAIT -> all outputs 0 asynchronously. A new load after release completes normally.
